// File: rtl/dom_slot_arbiter_pkg.sv
// Shared definitions for the domain slot arbiter: schedule state encoding,
// domain identifiers and the domain-to-label mapping.
package sec_arb_defs;

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SCRUB = 2'd2
  } slot_state_e;

  localparam logic DOM0 = 1'b0;
  localparam logic DOM1 = 1'b1;

  // Security lattice, ordered L < L1 < L2 < H.
  typedef enum logic [1:0] {
    LBL_L  = 2'd0,
    LBL_L1 = 2'd1,
    LBL_L2 = 2'd2,
    LBL_H  = 2'd3
  } label_e;

  // Label of anything tagged {Domain d}: domain 0 is L1, domain 1 is L2.
  function automatic label_e domain_label(input logic dom);
    return (dom == DOM1) ? LBL_L2 : LBL_L1;
  endfunction

endpackage

// File: rtl/dom_slot_arbiter_if.sv
// Requester-side bus of the domain slot arbiter: one write/read channel per
// domain. The arbiter takes the slave view, the requesters the master view.
interface dom_slot_arbiter_if #(
  parameter int DATA_W = 2
);
  logic              req0;
  logic [DATA_W-1:0] wdata0;
  logic              grant0;
  logic [DATA_W-1:0] rdata0;
  logic              req1;
  logic [DATA_W-1:0] wdata1;
  logic              grant1;
  logic [DATA_W-1:0] rdata1;

  modport slave (
    input  req0, wdata0, req1, wdata1,
    output grant0, rdata0, grant1, rdata1
  );

  modport master (
    output req0, wdata0, req1, wdata1,
    input  grant0, rdata0, grant1, rdata1
  );
endinterface

// File: rtl/dom_slot_arbiter_slot_timer.sv
// Fixed, request-independent schedule: SLOT0 and SLOT1 of SLOT_CYCLES cycles
// each, followed by one SCRUB cycle. Everything here is public (label L).
module slot_timer
  import sec_arb_defs::*;
#(
  parameter int SLOT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output slot_state_e state,
  output logic        cur_dom,
  output logic        scrub,
  output logic        scrub_load
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);

  slot_state_e   state_q, state_d;
  logic [CW-1:0] slot_cnt, slot_cnt_d;
  logic          last;

  assign last = (slot_cnt == LAST);

  // Schedule state and slot counter; reset restarts a full SLOT0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SLOT0;
      slot_cnt <= '0;
    end else begin
      state_q  <= state_d;
      slot_cnt <= slot_cnt_d;
    end
  end

  // Next schedule step; the counter wraps on every slot change and idles in SCRUB.
  always_comb begin
    state_d    = state_q;
    slot_cnt_d = '0;
    case (state_q)
      SLOT0: begin
        if (last) state_d = SLOT1;
        else      slot_cnt_d = slot_cnt + CW'(1);
      end
      SLOT1: begin
        if (last) state_d = SCRUB;
        else      slot_cnt_d = slot_cnt + CW'(1);
      end
      SCRUB:   state_d = SLOT0;
      default: state_d = SLOT0;
    endcase
  end

  assign state      = state_q;
  assign cur_dom    = (state_q == SLOT1) ? DOM1 : DOM0;
  assign scrub      = (state_q == SCRUB);
  // Final SLOT1 cycle: the coming edge is the L2->L1 hand-over that must clear.
  assign scrub_load = (state_q == SLOT1) && last;

endmodule

// File: rtl/dom_slot_arbiter.sv
// Two-domain time-multiplexed arbiter over one shared register. Domain 0 (L1)
// owns SLOT0, domain 1 (L2) owns SLOT1, and the register is cleared on the
// way back from L2 to L1 so that no L2 data is ever readable by L1.
module dom_slot_arbiter
  import sec_arb_defs::*;
#(
  parameter int SLOT_CYCLES = 8,
  parameter int DATA_W      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  dom_slot_arbiter_if.slave  bus,
  output logic               cur_dom,
  output logic               scrub
);

  slot_state_e       state;
  logic              scrub_load;
  logic              in_slot0, in_slot1;
  logic              grant0, grant1;
  // Label {Domain cur_dom}: L1 during SLOT0/SCRUB, L2 during SLOT1.
  logic [DATA_W-1:0] shared_q;

  slot_timer #(
    .SLOT_CYCLES(SLOT_CYCLES)
  ) u_slot_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state),
    .cur_dom   (cur_dom),
    .scrub     (scrub),
    .scrub_load(scrub_load)
  );

  assign in_slot0 = (state == SLOT0);
  assign in_slot1 = (state == SLOT1);

  // Reset also forces SLOT0, so grant0 is masked explicitly while rst_n is low.
  assign grant0 = rst_n & bus.req0 & in_slot0;
  assign grant1 = rst_n & bus.req1 & in_slot1;

  assign bus.grant0 = grant0;
  assign bus.grant1 = grant1;

  // Shared register: the scrub clear takes priority over a last-cycle L2 write,
  // and an L1 write flowing into the L2 slot is allowed to persist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          shared_q <= '0;
    else if (scrub_load) shared_q <= '0;
    else if (grant0)     shared_q <= bus.wdata0;
    else if (grant1)     shared_q <= bus.wdata1;
  end

  // Each domain sees the register only during its own slot.
  assign bus.rdata0 = in_slot0 ? shared_q : '0;
  assign bus.rdata1 = in_slot1 ? shared_q : '0;

endmodule

// File: tb/tb_dom_slot_arbiter.sv
// Bench for dom_slot_arbiter with SLOT_CYCLES=4 (period 9): directed scenarios
// followed by random requests, compared against a phase/value reference model.
module tb_dom_slot_arbiter;

  localparam int SC     = 4;
  localparam int PERIOD = 2 * SC + 1;
  localparam int DW     = 2;

  logic clk;
  logic rst_n;
  logic cur_dom;
  logic scrub;

  int n_checks;
  int n_errors;

  // Reference model: cycles since reset release and the shared value.
  int           t;
  logic [DW-1:0] m;

  dom_slot_arbiter_if #(.DATA_W(DW)) bus ();

  dom_slot_arbiter #(
    .SLOT_CYCLES(SC),
    .DATA_W     (DW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .cur_dom(cur_dom),
    .scrub  (scrub)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", tag, t, obs, exp);
    end
  endtask

  // Compare every output against the model for the current cycle.
  task automatic check_outputs();
    int  ph;
    logic s0, s1;
    ph = t % PERIOD;
    s0 = (ph < SC);
    s1 = (ph >= SC) && (ph < 2 * SC);
    chk("grant0",  bus.grant0, bus.req0 && s0);
    chk("grant1",  bus.grant1, bus.req1 && s1);
    chk("rdata0",  bus.rdata0, s0 ? m : '0);
    chk("rdata1",  bus.rdata1, s1 ? m : '0);
    chk("cur_dom", cur_dom, s1);
    chk("scrub",   scrub, ph == 2 * SC);
  endtask

  // One schedule cycle: drive, check away from the edge, advance model, clock.
  task automatic run_cycle(input logic r0, input logic [DW-1:0] w0,
                           input logic r1, input logic [DW-1:0] w1);
    int ph;
    bus.req0   = r0;
    bus.wdata0 = w0;
    bus.req1   = r1;
    bus.wdata1 = w1;
    #2;
    check_outputs();
    ph = t % PERIOD;
    if (ph < SC && r0)                   m = w0;
    else if (ph >= SC && ph < 2*SC && r1) m = w1;
    if (ph == 2 * SC - 1) m = '0;
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0, 1'b0, '0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    m = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    t = 0;
    m = '0;
    rst_n = 1'b0;
    bus.req0 = 1'b1;
    bus.wdata0 = 2'b11;
    bus.req1 = 1'b1;
    bus.wdata1 = 2'b11;

    // Reset state with requests asserted.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_grant0", bus.grant0, 0);
    chk("rst_grant1", bus.grant1, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_rdata1", bus.rdata1, 0);
    chk("rst_cur_dom", cur_dom, 0);
    chk("rst_scrub", scrub, 0);
    release_reset();

    // Schedule with no requests, plus a second period.
    idle(2 * PERIOD);

    // Period: L1 write in cycle 1, L2 write in cycle 5, then back to SLOT0.
    run_cycle(0, '0, 0, '0);
    run_cycle(1, 2'b10, 0, '0);
    idle(3);
    run_cycle(0, '0, 1, 2'b11);
    idle(3);
    idle(PERIOD);

    // Period: L1 write 01 in cycle 3 flows into SLOT1; L2 write in cycle 7 discarded.
    idle(3);
    run_cycle(1, 2'b01, 0, '0);
    idle(3);
    run_cycle(0, '0, 1, 2'b10);
    idle(1);
    idle(PERIOD);

    // req1 held high for 27 cycles.
    for (int i = 0; i < 27; i++) run_cycle(0, '0, 1, DW'(i));

    // Random traffic.
    for (int i = 0; i < 300; i++)
      run_cycle(($urandom % 3) == 0, DW'($urandom), ($urandom % 3) == 0, DW'($urandom));

    // Load 3 in SLOT1 then pulse reset mid-cycle.
    while ((t % PERIOD) != SC + 1) run_cycle(0, '0, 0, '0);
    run_cycle(0, '0, 1, 2'b11);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdata1", bus.rdata1, 0);
    chk("mid_rst_rdata0", bus.rdata0, 0);
    chk("mid_rst_cur_dom", cur_dom, 0);
    chk("mid_rst_grant0", bus.grant0, 0);
    chk("mid_rst_grant1", bus.grant1, 0);
    release_reset();
    #2;
    @(posedge clk);
    #1;
    t = 1;
    for (int i = 0; i < 3 * PERIOD; i++)
      run_cycle(($urandom % 2) == 0, DW'($urandom), ($urandom % 2) == 0, DW'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
